cpu_host_loader: RTL and testbench
==================================

// Module: cpu_host_loader
// PURPOSE
//  Host-side initiator for the CPU's external memory ports. Accepts a program as a 32-bit
//  valid/ready stream and writes it into instruction memory through the *_ext port. It then
//  asserts the CPU enable for a fixed number of cycles and streams the first DUMP_WORDS
//  data-memory words back out through the *_ext_2 port. Sits between testbench/host and cpu top.
// PARAMETERS
//  IMEM_WORDS  512   instruction memory capacity in 32-bit words
//  RUN_CYCLES  1000  cycles cpu_enable is held high, >=1
//  DUMP_WORDS  32    data memory 64-bit words read back, 1..1024
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset: one clock; reset is synchronous and active-high
//  start        in   1   begin a load/run/dump sequence, accepted only in IDLE or DONE
//  prog_valid   in   1   program word valid
//  prog_ready   out  1   loader accepts a word
//  prog_data    in   32  instruction word
//  prog_last    in   1   marks the final program word
//  dump_valid   out  1   dump word valid
//  dump_ready   in   1   consumer accepts the dump word
//  dump_data    out  64  data memory word
//  busy         out  1   high in any state except IDLE and DONE
//  done         out  1   sequence finished; held high until the next accepted start
//  err          out  1   sticky error: overflow or verify mismatch; cleared on start
//  cpu_enable   out  1   connects to cpu enable
//  addr_ext     out  64  instruction memory byte address = word_idx*4
//  wen_ext      out  1   instruction memory write strobe
//  ren_ext      out  1   instruction memory read strobe (verify only, else 0)
//  wdata_ext    out  32  instruction memory write data
//  rdata_ext    in   32  instruction memory read data, valid 1 cycle after ren_ext
//  addr_ext_2   out  64  data memory byte address = dump_idx*8
//  wen_ext_2    out  1   tied 0
//  ren_ext_2    out  1   data memory read strobe
//  wdata_ext_2  out  64  tied 0
//  rdata_ext_2  in   64  data memory read data, valid 1 cycle after ren_ext_2
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0, all counters are 0, and the dump holding register is 0.
//    Reset mid-sequence aborts immediately. The CPU's own arst_n is not driven by this block.
//  States: IDLE -> LOAD -> [VERIFY] -> RUN -> DUMP_RD -> DUMP_CAP -> DUMP_OUT -> ... -> DONE.
//  IDLE/DONE: start=1 -> LOAD. This clears done, err, word_idx and dump_idx. start is ignored elsewhere.
//  LOAD: prog_ready=1. On a beat (valid&ready), drive wen_ext=1, wdata_ext=prog_data and
//    addr_ext=word_idx*4 combinationally in the same cycle, then increment word_idx.
//    Beat with prog_last=1 -> RUN (or VERIFY); the word count is latched as n_words.
//    Overflow: if word IMEM_WORDS-1 is accepted without prog_last, set err and go to DONE. No run.
//    prog_ready is 0 from the next cycle.
//  RUN: cpu_enable=1 for exactly RUN_CYCLES consecutive cycles, counted by run_cnt. Then DUMP_RD.
//  DUMP_RD: ren_ext_2=1 for one cycle, addr_ext_2=dump_idx*8.
//  DUMP_CAP: register rdata_ext_2 into dump_data.
//  DUMP_OUT: dump_valid=1 with dump_data held stable until dump_ready. On the handshake,
//    dump_idx++. If dump_idx==DUMP_WORDS-1 go to DONE, else go to DUMP_RD.
//    dump_valid and dump_ready high in the same cycle as entry is a legal 1-cycle transfer.
//  Throughput: load 1 word/cycle; dump 1 word per 3 cycles maximum.
// CONFIGURATION
//  LOADER_READBACK_VERIFY_EN defined:
//    - LOAD accumulates sum_w (32-bit wrap add of prog_data).
//    - VERIFY reads words 0..n_words-1 via ren_ext, using the same 2-cycle read/capture pattern,
//      and accumulates sum_r.
//    - At the end: if sum_r!=sum_w, set err and go to DONE without RUN; else go to RUN.
//  Not defined: no VERIFY state, LOAD -> RUN directly, ren_ext tied 0, rdata_ext unused.
// TESTING
//  - Load 3 words {0x00500093,0x00A00113,0x002081B3} last on 3rd -> wen_ext at addr 0,4,8 with
//    those data; then cpu_enable high exactly RUN_CYCLES cycles.
//  - DUMP_WORDS=4, model dmem[i]=0x1111_0000+i, dump_ready toggling 1/0 -> dump_data sequence
//    0x11110000..0x11110003, each stable while dump_valid & !dump_ready; then done=1, busy=0.
//  - IMEM_WORDS=8, stream 9 words with no last -> 8 writes (addr 0..28), err=1, done=1,
//    cpu_enable never asserted.
//  - Assert rst during RUN at run_cnt=10 -> next cycle cpu_enable=0, busy=0, state IDLE;
//    start afterwards runs a full sequence.
//  - start pulsed during LOAD and during DUMP_OUT -> ignored; after DONE, start clears done and err.
//  - With LOADER_READBACK_VERIFY_EN, memory model corrupts word 1 -> err=1, no cpu_enable;
//    clean model -> ren_ext at addr 0,4,8 then RUN.

Source files
------------

// File: rtl/cpu_host_loader.sv
// -----------------------------------------------------------------------------
// cpu_host_loader
//
// Host-side initiator for the CPU's external memory ports. A sequence has
// four phases:
//   1. Load: a 32-bit valid/ready program stream is written into instruction
//      memory through the *_ext port.
//   2. Verify (optional): the program is read back and checked.
//   3. Run: cpu_enable is held high for RUN_CYCLES cycles.
//   4. Dump: the first DUMP_WORDS data-memory words are read through the
//      *_ext_2 port and streamed out through a valid/ready port.
//
// Optional feature, enabled by defining LOADER_READBACK_VERIFY_EN:
//   - LOAD keeps a 32-bit wrapping sum of the written words.
//   - VERIFY reads those words back and sums them again.
//   - If the two sums differ, err is set and the block goes to DONE without
//     running the CPU.
//   When the macro is undefined, LOAD goes straight to RUN, ren_ext is tied
//   to 0 and rdata_ext is ignored.
//
// Parameters
//   IMEM_WORDS   instruction memory capacity in 32-bit words
//   RUN_CYCLES   cycles cpu_enable is held high (>= 1)
//   DUMP_WORDS   64-bit data memory words read back (1..1024)
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start               begin a sequence (honoured only in IDLE or DONE)
//   prog_valid/ready/data/last    program input stream
//   dump_valid/ready/data         data-memory dump output stream
//   busy, done, err     status: busy outside IDLE/DONE; done held until the
//                       next accepted start; err is sticky until start
//   cpu_enable          CPU enable
//   *_ext               instruction memory port (byte address = word * 4)
//   *_ext_2             data memory port (byte address = word * 8), read only
// -----------------------------------------------------------------------------
module cpu_host_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int RUN_CYCLES = 1000,
    parameter int DUMP_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        prog_valid,
    output logic        prog_ready,
    input  logic [31:0] prog_data,
    input  logic        prog_last,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [63:0] dump_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_enable,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2
);

    localparam int WI_W = $clog2(IMEM_WORDS + 1);
    localparam int RC_W = $clog2(RUN_CYCLES + 1);
    localparam int DI_W = $clog2(DUMP_WORDS + 1);

    localparam logic [WI_W-1:0] IMEM_LAST = WI_W'(IMEM_WORDS - 1);
    localparam logic [RC_W-1:0] RUN_LAST  = RC_W'(RUN_CYCLES - 1);
    localparam logic [DI_W-1:0] DUMP_LAST = DI_W'(DUMP_WORDS - 1);
    localparam logic [WI_W-1:0] WI_ONE    = WI_W'(1);
    localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1);
    localparam logic [DI_W-1:0] DI_ONE    = DI_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_VFY_RD,
        S_VFY_CAP,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_CAP,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    state_t          state;
    logic [WI_W-1:0] word_idx;   // write index in LOAD, read index in VERIFY
    logic [RC_W-1:0] run_cnt;
    logic [DI_W-1:0] dump_idx;
    logic            prog_beat;

    // Outputs decoded from the state register.
    assign prog_ready  = (state == S_LOAD);
    assign cpu_enable  = (state == S_RUN);
    assign dump_valid  = (state == S_DUMP_OUT);
    assign ren_ext_2   = (state == S_DUMP_RD);
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);

    // NOTE: the write strobe is combinational from the handshake, so each
    // accepted word reaches memory in the same cycle it is accepted.
    assign prog_beat   = (state == S_LOAD) && prog_valid;
    assign wen_ext     = prog_beat;
    assign wdata_ext   = prog_beat ? prog_data : 32'd0;
    assign addr_ext    = 64'(word_idx) << 2;

    assign addr_ext_2  = 64'(dump_idx) << 3;
    assign wen_ext_2   = 1'b0;
    assign wdata_ext_2 = 64'd0;

`ifdef LOADER_READBACK_VERIFY_EN
    logic [31:0]     sum_w;
    logic [31:0]     sum_r;
    logic [31:0]     sum_r_next;
    logic [WI_W-1:0] n_words;

    assign ren_ext    = (state == S_VFY_RD);
    assign sum_r_next = sum_r + rdata_ext;
`else
    logic unused_rdata;

    assign ren_ext      = 1'b0;
    assign unused_rdata = ^rdata_ext;
`endif

    // NOTE: all state is updated with non-blocking assignments, so every
    // branch sees the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            word_idx  <= '0;
            run_cnt   <= '0;
            dump_idx  <= '0;
            dump_data <= '0;
            err       <= 1'b0;
`ifdef LOADER_READBACK_VERIFY_EN
            sum_w     <= '0;
            sum_r     <= '0;
            n_words   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        word_idx <= '0;
                        dump_idx <= '0;
                        run_cnt  <= '0;
                        err      <= 1'b0;
`ifdef LOADER_READBACK_VERIFY_EN
                        sum_w    <= '0;
                        sum_r    <= '0;
`endif
                    end
                end

                S_LOAD: begin
                    if (prog_valid) begin
                        word_idx <= word_idx + WI_ONE;
`ifdef LOADER_READBACK_VERIFY_EN
                        sum_w    <= sum_w + prog_data;
`endif
                        if (prog_last) begin
`ifdef LOADER_READBACK_VERIFY_EN
                            n_words  <= word_idx + WI_ONE;
                            word_idx <= '0;
                            state    <= S_VFY_RD;
`else
                            state    <= S_RUN;
`endif
                        end else if (word_idx == IMEM_LAST) begin
                            // Memory is full and the program has not ended.
                            err   <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

`ifdef LOADER_READBACK_VERIFY_EN
                S_VFY_RD: state <= S_VFY_CAP;

                S_VFY_CAP: begin
                    sum_r <= sum_r_next;
                    if (word_idx == n_words - WI_ONE) begin
                        if (sum_r_next != sum_w) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end else begin
                        word_idx <= word_idx + WI_ONE;
                        state    <= S_VFY_RD;
                    end
                end
`endif

                S_RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        run_cnt <= '0;
                        state   <= S_DUMP_RD;
                    end else begin
                        run_cnt <= run_cnt + RC_ONE;
                    end
                end

                S_DUMP_RD:  state <= S_DUMP_CAP;

                S_DUMP_CAP: begin
                    dump_data <= rdata_ext_2;
                    state     <= S_DUMP_OUT;
                end

                S_DUMP_OUT: begin
                    if (dump_ready) begin
                        dump_idx <= dump_idx + DI_ONE;
                        state    <= (dump_idx == DUMP_LAST) ? S_DONE : S_DUMP_RD;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_host_loader.sv
// -----------------------------------------------------------------------------
// tb_cpu_host_loader
//
// Self-checking bench for cpu_host_loader. It uses small parameters:
// IMEM_WORDS=8, RUN_CYCLES=20 and DUMP_WORDS=4.
//
// Expected traffic is queued before the stimulus is driven:
//   - instruction memory writes
//   - read-back addresses
//   - data memory read addresses
//   - dump words
// A per-cycle monitor pops these queues and compares them with the DUT
// outputs at the falling edge.
//
// Inputs are driven 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cpu_host_loader;

    localparam int IMEM_WORDS = 8;
    localparam int RUN_CYCLES = 20;
    localparam int DUMP_WORDS = 4;
    localparam int IA         = $clog2(IMEM_WORDS);
    localparam int BUDGET     = 400;

`ifdef LOADER_READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    localparam logic [31:0] PROG [3] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};

    logic        clk = 1'b0;
    logic        rst, start, prog_valid, prog_last, dump_ready;
    logic [31:0] prog_data;
    logic        prog_ready, dump_valid, busy, done, err, cpu_enable;
    logic [63:0] dump_data, addr_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext, rdata_ext;
    logic [63:0] rdata_ext_2;

    always #5 clk = ~clk;

    cpu_host_loader #(
        .IMEM_WORDS(IMEM_WORDS),
        .RUN_CYCLES(RUN_CYCLES),
        .DUMP_WORDS(DUMP_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_data  (prog_data),
        .prog_last  (prog_last),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_enable (cpu_enable),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .ren_ext    (ren_ext),
        .wdata_ext  (wdata_ext),
        .rdata_ext  (rdata_ext),
        .addr_ext_2 (addr_ext_2),
        .wen_ext_2  (wen_ext_2),
        .ren_ext_2  (ren_ext_2),
        .wdata_ext_2(wdata_ext_2),
        .rdata_ext_2(rdata_ext_2)
    );

    // Memory models.
    //   imem: ordinary RAM, with optional corruption of word 1 on read.
    //   dmem: returns 0x1111_0000 + word index.
    logic [31:0] imem [IMEM_WORDS];
    bit          corrupt = 1'b0;

    always @(posedge clk) begin
        if (wen_ext)
            imem[addr_ext[IA+1:2]] <= wdata_ext;
        if (ren_ext)
            rdata_ext <= imem[addr_ext[IA+1:2]]
                         ^ ((corrupt && addr_ext[IA+1:2] == IA'(1)) ? 32'h1 : 32'h0);
        if (ren_ext_2)
            rdata_ext_2 <= 64'h1111_0000 + (addr_ext_2 >> 3);
    end

    // Scoreboard queues and counters.
    logic [95:0] wr_q   [$];   // {addr, data} of expected imem writes
    logic [63:0] rd_q   [$];   // expected imem read-back addresses
    logic [63:0] rd2_q  [$];   // expected dmem read addresses
    logic [63:0] dump_q [$];   // expected dump words

    int  errors = 0;
    int  checks = 0;
    int  en_cnt = 0;
    int  en_seg = 0;
    bit  prev_en = 1'b0;

    task automatic monitor();
        logic [95:0] w;
        logic [63:0] a;
        if (cpu_enable) begin
            en_cnt++;
            if (!prev_en) en_seg++;
        end
        prev_en = cpu_enable;

        if (wen_ext) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL imem_write: got addr=%0h data=%0h, required no write",
                         addr_ext, wdata_ext);
            end else begin
                w = wr_q.pop_front();
                if ({addr_ext, wdata_ext} !== w) begin
                    errors++;
                    $display("FAIL imem_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             addr_ext, wdata_ext, w[95:32], w[31:0]);
                end
            end
        end

        if (ren_ext) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL imem_read: got addr=%0h, required no read", addr_ext);
            end else begin
                a = rd_q.pop_front();
                if (addr_ext !== a) begin
                    errors++;
                    $display("FAIL imem_read: got addr=%0h, required %0h", addr_ext, a);
                end
            end
        end

        if (ren_ext_2) begin
            checks++;
            if (rd2_q.size() == 0) begin
                errors++;
                $display("FAIL dmem_read: got addr=%0h, required no read", addr_ext_2);
            end else begin
                a = rd2_q.pop_front();
                if (addr_ext_2 !== a) begin
                    errors++;
                    $display("FAIL dmem_read: got addr=%0h, required %0h", addr_ext_2, a);
                end
            end
        end

        // Compared every valid cycle, so a word that changes while stalled is
        // caught as well.
        if (dump_valid) begin
            checks++;
            if (dump_q.size() == 0) begin
                errors++;
                $display("FAIL dump_word: got %0h, required no dump", dump_data);
            end else begin
                if (dump_data !== dump_q[0]) begin
                    errors++;
                    $display("FAIL dump_word: got %0h, required %0h", dump_data, dump_q[0]);
                end
                if (dump_ready) void'(dump_q.pop_front());
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last,
                             input logic exp_ready, input string tag);
        prog_valid = 1'b1;
        prog_data  = d;
        prog_last  = last;
        checks++;
        if (prog_ready !== exp_ready) begin
            errors++;
            $display("FAIL %s_prog_ready: got %b, required %b", tag, prog_ready, exp_ready);
        end
        step();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        prog_data  = 32'd0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < BUDGET) begin
            dump_ready = ~dump_ready;
            step();
            n++;
        end
        dump_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", tag, done, n);
        end
    endtask

    // Queue the traffic of one 3-word program load.
    task automatic push_expected(input bit exp_run, input bit exp_verify);
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back({64'(i * 4), PROG[i]});
            if (exp_verify) rd_q.push_back(64'(i * 4));
        end
        if (exp_run) begin
            for (int i = 0; i < DUMP_WORDS; i++) begin
                rd2_q.push_back(64'(i * 8));
                dump_q.push_back(64'h1111_0000 + 64'(i));
            end
        end
    endtask

    task automatic end_checks(input string tag, input int en0, input int seg0,
                              input bit exp_run, input bit exp_err);
        int exp_en;
        int exp_seg;
        int left;
        exp_en  = exp_run ? RUN_CYCLES : 0;
        exp_seg = exp_run ? 1 : 0;
        left    = wr_q.size() + rd_q.size() + rd2_q.size() + dump_q.size();

        checks++;
        if (en_cnt - en0 !== exp_en) begin
            errors++;
            $display("FAIL %s_run_cycles: got %0d, required %0d", tag, en_cnt - en0, exp_en);
        end

        checks++;
        if (en_seg - seg0 !== exp_seg) begin
            errors++;
            $display("FAIL %s_run_bursts: got %0d, required %0d", tag, en_seg - seg0, exp_seg);
        end

        checks++;
        if ({err, busy, done} !== {exp_err, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s_status: got err/busy/done=%b%b%b, required %b01",
                     tag, err, busy, done, exp_err);
        end

        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d expected transfers missing, required 0", tag, left);
        end

        wr_q.delete();
        rd_q.delete();
        rd2_q.delete();
        dump_q.delete();
    endtask

    // Full load/run/dump sequence.
    //   exp_run = 0: verify is expected to reject the program.
    task automatic run_sequence(input string tag, input bit exp_run);
        int en0  = en_cnt;
        int seg0 = en_seg;
        push_expected(exp_run, VERIFY);
        pulse_start();
        checks++;
        if ({prog_ready, busy, done, err} !== 4'b1100) begin
            errors++;
            $display("FAIL %s_after_start: got ready/busy/done/err=%b%b%b%b, required 1100",
                     tag, prog_ready, busy, done, err);
        end
        for (int i = 0; i < 3; i++) send_word(PROG[i], i == 2, 1'b1, tag);
        wait_done(tag);
        end_checks(tag, en0, seg0, exp_run, !exp_run);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({busy, done, err, cpu_enable, prog_ready, dump_valid,
             wen_ext, ren_ext, wen_ext_2, ren_ext_2} !== 10'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0",
                     {busy, done, err, cpu_enable, prog_ready, dump_valid,
                      wen_ext, ren_ext, wen_ext_2, ren_ext_2});
        end
        checks++;
        if ({addr_ext, addr_ext_2, wdata_ext, wdata_ext_2} !== 224'd0) begin
            errors++;
            $display("FAIL reset_buses: got addr=%0h addr2=%0h wd=%0h wd2=%0h, required 0",
                     addr_ext, addr_ext_2, wdata_ext, wdata_ext_2);
        end
        checks++;
        if (dump_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_dump_data: got %0h, required 0", dump_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        int en0  = en_cnt;
        int seg0 = en_seg;
        pulse_start();
        for (int i = 0; i < IMEM_WORDS + 1; i++) begin
            if (i < IMEM_WORDS) wr_q.push_back({64'(i * 4), 32'hA000_0000 + 32'(i)});
            send_word(32'hA000_0000 + 32'(i), 1'b0, i < IMEM_WORDS, "overflow");
        end
        end_checks("overflow", en0, seg0, 1'b0, 1'b1);
    endtask

    task automatic test_start_clears();
        checks++;
        if ({done, err} !== 2'b11) begin
            errors++;
            $display("FAIL clear_precond: got done/err=%b%b, required 11", done, err);
        end
        run_sequence("clear", 1'b1);
    endtask

    task automatic test_start_ignored();
        int en0  = en_cnt;
        int seg0 = en_seg;
        int n    = 0;
        push_expected(1'b1, VERIFY);
        pulse_start();
        send_word(PROG[0], 1'b0, 1'b1, "ign");

        // A restart here would reset word_idx; the next write address would
        // then be wrong.
        pulse_start();
        checks++;
        if ({prog_ready, busy} !== 2'b11) begin
            errors++;
            $display("FAIL ign_load_start: got ready/busy=%b%b, required 11", prog_ready, busy);
        end

        send_word(PROG[1], 1'b0, 1'b1, "ign");
        send_word(PROG[2], 1'b1, 1'b1, "ign");

        dump_ready = 1'b0;
        while (!dump_valid && n < BUDGET) begin
            step();
            n++;
        end
        pulse_start();
        checks++;
        if ({dump_valid, busy, done} !== 3'b110) begin
            errors++;
            $display("FAIL ign_dump_start: got valid/busy/done=%b%b%b, required 110",
                     dump_valid, busy, done);
        end

        wait_done("ign");
        end_checks("ign", en0, seg0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_during_run();
        int en0 = en_cnt;
        int n   = 0;
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back({64'(i * 4), PROG[i]});
            if (VERIFY) rd_q.push_back(64'(i * 4));
        end
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(PROG[i], i == 2, 1'b1, "rstrun");

        while (en_cnt - en0 < 10 && n < BUDGET) begin
            step();
            n++;
        end
        checks++;
        if (cpu_enable !== 1'b1) begin
            errors++;
            $display("FAIL rstrun_in_run: got cpu_enable=%b, required 1", cpu_enable);
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({cpu_enable, busy, done, prog_ready, dump_valid} !== 5'd0) begin
            errors++;
            $display("FAIL rstrun_abort: got en/busy/done/ready/valid=%b, required 00000",
                     {cpu_enable, busy, done, prog_ready, dump_valid});
        end

        wr_q.delete();
        rd_q.delete();
        run_sequence("after_rst", 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        prog_data  = 32'd0;
        dump_ready = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        run_sequence("basic", 1'b1);
        test_overflow();
        test_start_clears();
        test_start_ignored();
        test_reset_during_run();
        if (VERIFY) begin
            corrupt = 1'b1;
            run_sequence("verify_bad", 1'b0);
            corrupt = 1'b0;
            run_sequence("verify_ok", 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
